// File: rtl/wasd_move_controller.sv
// WASD cursor controller: PS/2 set-2 parser, held-key arbitration, autorepeat stepping and X/Y position.
// Optional macro WASD_POS_WRAP_EN: modulo position arithmetic instead of saturation.
module wasd_move_controller #(
    parameter int POS_W         = 4,
    parameter int CNT_W         = 16,
    parameter int REPEAT_DELAY  = 200,
    parameter int REPEAT_PERIOD = 50
) (
    input  logic             Clock,
    input  logic             Reset,
    input  logic [7:0]       iData,
    input  logic             iDataValid,
    output logic [POS_W-1:0] oPositionX,
    output logic [POS_W-1:0] oPositionY,
    output logic             oMoveStrobe,
    output logic [1:0]       oMoveDir,
    output logic [3:0]       oKeyHeld
);

    typedef enum logic [1:0] {P_IDLE, P_BREAK, P_EXT, P_EXT_BRK} pstate_t;
    typedef enum logic [1:0] {R_IDLE, R_DELAY, R_REPEAT} rstate_t;

    localparam logic [7:0]       CODE_W   = 8'h1D;
    localparam logic [7:0]       CODE_A   = 8'h1C;
    localparam logic [7:0]       CODE_S   = 8'h1B;
    localparam logic [7:0]       CODE_D   = 8'h23;
    localparam logic [7:0]       CODE_BRK = 8'hF0;
    localparam logic [7:0]       CODE_EXT = 8'hE0;
    localparam logic [CNT_W-1:0] DLY_LAST = CNT_W'(REPEAT_DELAY - 1);
    localparam logic [CNT_W-1:0] PER_LAST = CNT_W'(REPEAT_PERIOD - 1);
    localparam logic [POS_W-1:0] POS_MAX  = {POS_W{1'b1}};

    pstate_t          r_pstate, w_pstate_nxt;
    rstate_t          r_rstate, w_rstate_nxt;
    logic [CNT_W-1:0] r_timer, w_timer_nxt;
    logic [3:0]       r_held, w_held_nxt, w_remaining;
    logic [1:0]       r_active, w_active_nxt;
    logic [1:0]       r_dir, w_dir_nxt;
    logic             r_strobe, w_step;
    logic [POS_W-1:0] r_x, r_y, w_x_nxt, w_y_nxt;
    logic             w_is_wasd, w_make, w_brk, w_make_new, w_brk_held, w_brk_active, w_expire;
    logic [1:0]       w_key;

    function automatic logic [POS_W-1:0] pos_inc(input logic [POS_W-1:0] p);
`ifdef WASD_POS_WRAP_EN
        return p + 1'b1;
`else
        return (p == POS_MAX) ? p : p + 1'b1;
`endif
    endfunction

    function automatic logic [POS_W-1:0] pos_dec(input logic [POS_W-1:0] p);
`ifdef WASD_POS_WRAP_EN
        return p - 1'b1;
`else
        return (p == '0) ? p : p - 1'b1;
`endif
    endfunction

    // Fixed priority W > A > S > D among the keys still held.
    function automatic logic [1:0] prio_key(input logic [3:0] m);
        if (m[0])      return 2'd0;
        else if (m[1]) return 2'd1;
        else if (m[2]) return 2'd2;
        else           return 2'd3;
    endfunction

    always_comb begin
        w_is_wasd = 1'b1;
        w_key     = 2'd0;
        case (iData)
            CODE_W:  w_key = 2'd0;
            CODE_A:  w_key = 2'd1;
            CODE_S:  w_key = 2'd2;
            CODE_D:  w_key = 2'd3;
            default: w_is_wasd = 1'b0;
        endcase
    end

    assign w_make       = iDataValid && (r_pstate == P_IDLE) && w_is_wasd;
    assign w_brk        = iDataValid && (r_pstate == P_BREAK) && w_is_wasd;
    assign w_make_new   = w_make && !r_held[w_key];
    assign w_brk_held   = w_brk && r_held[w_key];
    assign w_brk_active = w_brk_held && (w_key == r_active);
    assign w_remaining  = r_held & ~(4'b0001 << w_key);
    assign w_expire     = ((r_rstate == R_DELAY) && (r_timer == DLY_LAST)) ||
                          ((r_rstate == R_REPEAT) && (r_timer == PER_LAST));

    always_comb begin
        w_pstate_nxt = r_pstate;
        if (iDataValid) begin
            case (r_pstate)
                P_IDLE: begin
                    if (iData == CODE_BRK)      w_pstate_nxt = P_BREAK;
                    else if (iData == CODE_EXT) w_pstate_nxt = P_EXT;
                end
                P_EXT:   w_pstate_nxt = (iData == CODE_BRK) ? P_EXT_BRK : P_IDLE;
                default: w_pstate_nxt = P_IDLE;
            endcase
        end
    end

    // A new make outranks a coinciding timer expiry; breaking the active key restarts the delay.
    always_comb begin
        w_held_nxt   = r_held;
        w_active_nxt = r_active;
        w_rstate_nxt = r_rstate;
        w_timer_nxt  = (r_rstate == R_IDLE) ? '0 : r_timer + 1'b1;
        w_step       = 1'b0;
        w_dir_nxt    = r_dir;
        if (w_make_new) begin
            w_held_nxt   = r_held | (4'b0001 << w_key);
            w_active_nxt = w_key;
            w_rstate_nxt = R_DELAY;
            w_timer_nxt  = '0;
            w_step       = 1'b1;
            w_dir_nxt    = w_key;
        end else if (w_brk_active) begin
            w_held_nxt  = w_remaining;
            w_timer_nxt = '0;
            if (w_remaining != 4'b0000) begin
                w_active_nxt = prio_key(w_remaining);
                w_rstate_nxt = R_DELAY;
            end else begin
                w_rstate_nxt = R_IDLE;
            end
        end else begin
            if (w_brk_held)
                w_held_nxt = w_remaining;
            if (w_expire) begin
                w_step       = 1'b1;
                w_dir_nxt    = r_active;
                w_rstate_nxt = R_REPEAT;
                w_timer_nxt  = '0;
            end
        end
    end

    always_comb begin
        w_x_nxt = r_x;
        w_y_nxt = r_y;
        if (w_step) begin
            case (w_dir_nxt)
                2'd0:    w_y_nxt = pos_inc(r_y);
                2'd1:    w_x_nxt = pos_dec(r_x);
                2'd2:    w_y_nxt = pos_dec(r_y);
                default: w_x_nxt = pos_inc(r_x);
            endcase
        end
    end

    always_ff @(posedge Clock) begin
        if (Reset) begin
            r_pstate <= P_IDLE;
            r_rstate <= R_IDLE;
            r_timer  <= '0;
            r_held   <= '0;
            r_active <= '0;
            r_dir    <= '0;
            r_strobe <= 1'b0;
            r_x      <= '0;
            r_y      <= '0;
        end else begin
            r_pstate <= w_pstate_nxt;
            r_rstate <= w_rstate_nxt;
            r_timer  <= w_timer_nxt;
            r_held   <= w_held_nxt;
            r_active <= w_active_nxt;
            r_dir    <= w_dir_nxt;
            r_strobe <= w_step;
            r_x      <= w_x_nxt;
            r_y      <= w_y_nxt;
        end
    end

    assign oPositionX  = r_x;
    assign oPositionY  = r_y;
    assign oMoveStrobe = r_strobe;
    assign oMoveDir    = r_dir;
    assign oKeyHeld    = r_held;

endmodule

// File: tb/tb_wasd_move_controller.sv
// Bench for wasd_move_controller: table of back-to-back bytes plus timed autorepeat sequences.
module tb_wasd_move_controller;

`ifdef WASD_POS_WRAP_EN
    localparam bit WRAP = 1'b1;
`else
    localparam bit WRAP = 1'b0;
`endif

    logic       Clock = 1'b0;
    logic       Reset = 1'b0;
    logic [7:0] iData = 8'h00;
    logic       iDataValid = 1'b0;
    logic [3:0] oPositionX, oPositionY;
    logic       oMoveStrobe;
    logic [1:0] oMoveDir;
    logic [3:0] oKeyHeld;

    int nvec  = 0;
    int nfail = 0;

    wasd_move_controller #(.POS_W(4), .CNT_W(16), .REPEAT_DELAY(200), .REPEAT_PERIOD(50)) dut (
        .Clock(Clock), .Reset(Reset), .iData(iData), .iDataValid(iDataValid),
        .oPositionX(oPositionX), .oPositionY(oPositionY), .oMoveStrobe(oMoveStrobe),
        .oMoveDir(oMoveDir), .oKeyHeld(oKeyHeld)
    );

    always #5 Clock = ~Clock;

    typedef struct {
        logic [7:0] data;
        logic       stb;
        logic [1:0] dir;
        logic [3:0] x;
        logic [3:0] y;
        logic [3:0] held;
    } vec_t;

    vec_t tbl[22];

    function automatic vec_t mk(logic [7:0] d, logic s, logic [1:0] dr, logic [3:0] x, logic [3:0] y, logic [3:0] h);
        vec_t v;
        v.data = d; v.stb = s; v.dir = dr; v.x = x; v.y = y; v.held = h;
        return v;
    endfunction

    task automatic chk(input string nm, input int act, input int exp);
        nvec++;
        if (act != exp) begin
            nfail++;
            $display("FAIL %s: got %0d, expected %0d", nm, act, exp);
        end
    endtask

    task automatic send(input logic [7:0] b);
        @(negedge Clock);
        iData = b;
        iDataValid = 1'b1;
        @(posedge Clock);
        #1;
        iDataValid = 1'b0;
    endtask

    task automatic idle(input int n);
        repeat (n) @(posedge Clock);
        #1;
    endtask

    task automatic do_reset();
        @(negedge Clock);
        Reset = 1'b1;
        repeat (3) @(posedge Clock);
        #1;
        Reset = 1'b0;
    endtask

    task automatic wait_strobe(input int max, output int n);
        n = 0;
        do begin
            @(posedge Clock);
            #1;
            n++;
        end while (!oMoveStrobe && n < max);
    endtask

    task automatic count_strobes(input int ncyc, output int cnt);
        cnt = 0;
        repeat (ncyc) begin
            @(posedge Clock);
            #1;
            if (oMoveStrobe) cnt++;
        end
    endtask

    initial begin
        int n;
        logic [3:0] wv;
        wv = WRAP ? 4'd15 : 4'd0;
        tbl[0]  = mk(8'h1D, 1, 0, 0, 1,  4'h1);
        tbl[1]  = mk(8'h1D, 0, 0, 0, 1,  4'h1);
        tbl[2]  = mk(8'h23, 1, 3, 1, 1,  4'h9);
        tbl[3]  = mk(8'h1C, 1, 1, 0, 1,  4'hB);
        tbl[4]  = mk(8'h1C, 0, 1, 0, 1,  4'hB);
        tbl[5]  = mk(8'hF0, 0, 1, 0, 1,  4'hB);
        tbl[6]  = mk(8'h1D, 0, 1, 0, 1,  4'hA);
        tbl[7]  = mk(8'hE0, 0, 1, 0, 1,  4'hA);
        tbl[8]  = mk(8'h1D, 0, 1, 0, 1,  4'hA);
        tbl[9]  = mk(8'hE0, 0, 1, 0, 1,  4'hA);
        tbl[10] = mk(8'hF0, 0, 1, 0, 1,  4'hA);
        tbl[11] = mk(8'h1D, 0, 1, 0, 1,  4'hA);
        tbl[12] = mk(8'h1B, 1, 2, 0, 0,  4'hE);
        tbl[13] = mk(8'hF0, 0, 2, 0, 0,  4'hE);
        tbl[14] = mk(8'h1B, 0, 2, 0, 0,  4'hA);
        tbl[15] = mk(8'h1B, 1, 2, 0, wv, 4'hE);
        tbl[16] = mk(8'h33, 0, 2, 0, wv, 4'hE);
        tbl[17] = mk(8'hF0, 0, 2, 0, wv, 4'hE);
        tbl[18] = mk(8'h33, 0, 2, 0, wv, 4'hE);
        tbl[19] = mk(8'hF0, 0, 2, 0, wv, 4'hE);
        tbl[20] = mk(8'h1C, 0, 2, 0, wv, 4'hC);
        tbl[21] = mk(8'h1C, 1, 1, wv, wv, 4'hE);

        do_reset();
        chk("rst_x", oPositionX, 0);
        chk("rst_y", oPositionY, 0);
        chk("rst_stb", oMoveStrobe, 0);
        chk("rst_dir", oMoveDir, 0);
        chk("rst_held", oKeyHeld, 0);

        for (int i = 0; i < 22; i++) begin
            send(tbl[i].data);
            chk($sformatf("v%0d_stb", i),  oMoveStrobe, tbl[i].stb);
            chk($sformatf("v%0d_dir", i),  oMoveDir,    tbl[i].dir);
            chk($sformatf("v%0d_x", i),    oPositionX,  tbl[i].x);
            chk($sformatf("v%0d_y", i),    oPositionY,  tbl[i].y);
            chk($sformatf("v%0d_held", i), oKeyHeld,    tbl[i].held);
        end

        // Reset in the middle of a hold clears everything and stays quiet.
        do_reset();
        send(8'h1D);
        idle(120);
        do_reset();
        chk("midrst_x", oPositionX, 0);
        chk("midrst_y", oPositionY, 0);
        chk("midrst_held", oKeyHeld, 0);
        chk("midrst_stb", oMoveStrobe, 0);
        count_strobes(300, n);
        chk("midrst_quiet", n, 0);

        // Initial step, delay, then periodic autorepeat.
        send(8'h1D);
        chk("rep_first_stb", oMoveStrobe, 1);
        chk("rep_first_y", oPositionY, 1);
        wait_strobe(260, n);
        chk("rep_delay", n, 200);
        chk("rep_y2", oPositionY, 2);
        wait_strobe(80, n);
        chk("rep_period1", n, 50);
        chk("rep_y3", oPositionY, 3);
        wait_strobe(80, n);
        chk("rep_period2", n, 50);
        chk("rep_y4", oPositionY, 4);

        // Release stops everything.
        send(8'hF0);
        send(8'h1D);
        chk("rel_held", oKeyHeld, 0);
        count_strobes(1000, n);
        chk("rel_quiet", n, 0);
        chk("rel_y", oPositionY, 4);

        // Second key pre-empts, releasing it reverts to W after a full delay.
        send(8'h1D);
        chk("pre_w_y", oPositionY, 5);
        send(8'h23);
        chk("pre_d_stb", oMoveStrobe, 1);
        chk("pre_d_dir", oMoveDir, 3);
        chk("pre_d_x", oPositionX, 1);
        send(8'hF0);
        send(8'h23);
        chk("pre_brk_stb", oMoveStrobe, 0);
        chk("pre_brk_held", oKeyHeld, 1);
        wait_strobe(260, n);
        chk("pre_revert_wait", n, 200);
        chk("pre_revert_dir", oMoveDir, 0);
        chk("pre_revert_y", oPositionY, 6);

        // Climb to the top edge, then one step past it.
        do_reset();
        send(8'h1D);
        for (int k = 2; k <= 15; k++) begin
            wait_strobe(260, n);
            chk($sformatf("climb_wait%0d", k), n, (k == 2) ? 200 : 50);
            chk($sformatf("climb_y%0d", k), oPositionY, k);
        end
        wait_strobe(80, n);
        chk("top_wait", n, 50);
        chk("top_stb", oMoveStrobe, 1);
        chk("top_y", oPositionY, WRAP ? 0 : 15);

        // Make arrives on the exact edge the repeat timer expires.
        do_reset();
        send(8'h1D);
        wait_strobe(260, n);
        chk("coin_delay", n, 200);
        idle(49);
        send(8'h23);
        chk("coin_stb", oMoveStrobe, 1);
        chk("coin_dir", oMoveDir, 3);
        chk("coin_x", oPositionX, 1);
        chk("coin_y", oPositionY, 2);
        count_strobes(199, n);
        chk("coin_quiet", n, 0);
        idle(1);
        chk("coin_next_stb", oMoveStrobe, 1);
        chk("coin_next_dir", oMoveDir, 3);
        chk("coin_next_x", oPositionX, 2);

        $display("== %0d vectors applied, %0d miscompares ==", nvec, nfail);
        $finish;
    end

endmodule
